// File: rtl/mul_issue_queue_pkg.sv
// Shared constants for the multiplier issue queue: the default entry count,
// operand width, rename-tag width and speculative-tag width.
package mul_issue_queue_pkg;

  localparam int MUL_ENTRY_NUM   = 4;
  localparam int MUL_DATA_LEN    = 32;
  localparam int MUL_RRF_SEL     = 6;
  localparam int MUL_SPECTAG_LEN = 5;

endpackage

// File: rtl/mul_issue_queue_if.sv
// Dispatch, forwarding, branch-resolution and issue signals of the multiplier
// issue queue. The queue itself connects through the master modport; the
// surrounding pipeline and execution unit use the slave modport.
// Optional output stall_cnt exists only when MUL_STALL_CNT_EN is defined.
interface mul_issue_queue_if
  import mul_issue_queue_pkg::*;
#(
  parameter int DATA_LEN    = MUL_DATA_LEN,
  parameter int RRF_SEL     = MUL_RRF_SEL,
  parameter int SPECTAG_LEN = MUL_SPECTAG_LEN
);

  // Dispatch side
  logic                   we;
  logic [DATA_LEN-1:0]    wr_src1;
  logic [DATA_LEN-1:0]    wr_src2;
  logic                   wr_src1_vld;
  logic                   wr_src2_vld;
  logic                   wr_dstval;
  logic [RRF_SEL-1:0]     wr_rrftag;
  logic [SPECTAG_LEN-1:0] wr_spectag;
  logic                   wr_specbit;
  logic                   wr_src1_signed;
  logic                   wr_src2_signed;
  logic                   wr_sel_lohi;
  logic                   full;

  // Result-forwarding buses
  logic                   fwd0_we;
  logic [RRF_SEL-1:0]     fwd0_tag;
  logic [DATA_LEN-1:0]    fwd0_data;
  logic                   fwd1_we;
  logic [RRF_SEL-1:0]     fwd1_tag;
  logic [DATA_LEN-1:0]    fwd1_data;

  // Branch resolution
  logic                   prmiss;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] spectagfix;

  // Execution-unit side
  logic                   ex_done;
  logic                   issue;
  logic [DATA_LEN-1:0]    ex_src1;
  logic [DATA_LEN-1:0]    ex_src2;
  logic                   ex_dstval;
  logic [RRF_SEL-1:0]     ex_rrftag;
  logic [SPECTAG_LEN-1:0] ex_spectag;
  logic                   ex_specbit;
  logic                   ex_src1_signed;
  logic                   ex_src2_signed;
  logic                   ex_sel_lohi;
  logic                   unit_busy;
`ifdef MUL_STALL_CNT_EN
  logic [31:0]            stall_cnt;
`endif

  modport master (
    input  we, wr_src1, wr_src2, wr_src1_vld, wr_src2_vld, wr_dstval, wr_rrftag,
           wr_spectag, wr_specbit, wr_src1_signed, wr_src2_signed, wr_sel_lohi,
           fwd0_we, fwd0_tag, fwd0_data, fwd1_we, fwd1_tag, fwd1_data,
           prmiss, prsuccess, spectagfix, ex_done,
    output full, issue, ex_src1, ex_src2, ex_dstval, ex_rrftag, ex_spectag,
           ex_specbit, ex_src1_signed, ex_src2_signed, ex_sel_lohi, unit_busy
`ifdef MUL_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output we, wr_src1, wr_src2, wr_src1_vld, wr_src2_vld, wr_dstval, wr_rrftag,
           wr_spectag, wr_specbit, wr_src1_signed, wr_src2_signed, wr_sel_lohi,
           fwd0_we, fwd0_tag, fwd0_data, fwd1_we, fwd1_tag, fwd1_data,
           prmiss, prsuccess, spectagfix, ex_done,
    input  full, issue, ex_src1, ex_src2, ex_dstval, ex_rrftag, ex_spectag,
           ex_specbit, ex_src1_signed, ex_src2_signed, ex_sel_lohi, unit_busy
`ifdef MUL_STALL_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/mul_rs_entry.sv
// One reservation-station entry: operand/control storage, tag wakeup from
// both forwarding buses (fwd0 has priority), branch kill and branch-success
// update, and a ready flag computed from registered state only.
module mul_rs_entry
  import mul_issue_queue_pkg::*;
#(
  parameter int DATA_LEN    = MUL_DATA_LEN,
  parameter int RRF_SEL     = MUL_RRF_SEL,
  parameter int SPECTAG_LEN = MUL_SPECTAG_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_LEN-1:0]    wr_src1,
  input  logic [DATA_LEN-1:0]    wr_src2,
  input  logic                   wr_src1_vld,
  input  logic                   wr_src2_vld,
  input  logic                   wr_dstval,
  input  logic [RRF_SEL-1:0]     wr_rrftag,
  input  logic [SPECTAG_LEN-1:0] wr_spectag,
  input  logic                   wr_specbit,
  input  logic                   wr_src1_signed,
  input  logic                   wr_src2_signed,
  input  logic                   wr_sel_lohi,
  input  logic                   fwd0_we,
  input  logic [RRF_SEL-1:0]     fwd0_tag,
  input  logic [DATA_LEN-1:0]    fwd0_data,
  input  logic                   fwd1_we,
  input  logic [RRF_SEL-1:0]     fwd1_tag,
  input  logic [DATA_LEN-1:0]    fwd1_data,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  input  logic                   clear,
  output logic                   vld,
  output logic                   ready,
  output logic                   kill_hit,
  output logic [DATA_LEN-1:0]    src1,
  output logic [DATA_LEN-1:0]    src2,
  output logic                   dstval,
  output logic [RRF_SEL-1:0]     rrftag,
  output logic [SPECTAG_LEN-1:0] spectag,
  output logic                   specbit,
  output logic                   src1_signed,
  output logic                   src2_signed,
  output logic                   sel_lohi
);

  logic                src1_vld, src2_vld;
  logic [DATA_LEN-1:0] src1_nxt, src2_nxt;
  logic                src1_vld_nxt, src2_vld_nxt;
  logic                wr_kill;
  logic                wr_success;
  logic                success_hit;

  assign kill_hit    = vld && specbit && prmiss && |(spectag & spectagfix);
  assign success_hit = prsuccess && |(spectag & spectagfix);
  assign wr_kill     = prmiss && wr_specbit && |(wr_spectag & spectagfix);
  assign wr_success  = prsuccess && |(wr_spectag & spectagfix);
  assign ready       = vld && src1_vld && src2_vld;

  // Operand next-state: take the dispatched or stored operand, then let a
  // matching forwarding bus fill it in if it is still a tag.
  // NOTE: every variable gets a default before any condition so no latch is inferred;
  // combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    src1_nxt     = wr_en ? wr_src1 : src1;
    src1_vld_nxt = wr_en ? wr_src1_vld : src1_vld;
    src2_nxt     = wr_en ? wr_src2 : src2;
    src2_vld_nxt = wr_en ? wr_src2_vld : src2_vld;
    if (!src1_vld_nxt) begin
      if (fwd0_we && (fwd0_tag == src1_nxt[RRF_SEL-1:0])) begin
        src1_nxt     = fwd0_data;
        src1_vld_nxt = 1'b1;
      end else if (fwd1_we && (fwd1_tag == src1_nxt[RRF_SEL-1:0])) begin
        src1_nxt     = fwd1_data;
        src1_vld_nxt = 1'b1;
      end
    end
    if (!src2_vld_nxt) begin
      if (fwd0_we && (fwd0_tag == src2_nxt[RRF_SEL-1:0])) begin
        src2_nxt     = fwd0_data;
        src2_vld_nxt = 1'b1;
      end else if (fwd1_we && (fwd1_tag == src2_nxt[RRF_SEL-1:0])) begin
        src2_nxt     = fwd1_data;
        src2_vld_nxt = 1'b1;
      end
    end
  end

  // Entry occupancy: dispatch (unless killed on arrival), issue and kill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
    end else if (wr_en) begin
      vld <= !wr_kill;
    end else if (clear || kill_hit) begin
      vld <= 1'b0;
    end
  end

  // Payload storage, qualified by vld everywhere it is consumed.
  // NOTE: payload registers carry no reset; only the valid bit must be cleared.
  always_ff @(posedge clk) begin
    src1     <= src1_nxt;
    src1_vld <= src1_vld_nxt;
    src2     <= src2_nxt;
    src2_vld <= src2_vld_nxt;
    if (wr_en) begin
      dstval      <= wr_dstval;
      rrftag      <= wr_rrftag;
      spectag     <= wr_spectag;
      specbit     <= wr_specbit && !wr_success;
      src1_signed <= wr_src1_signed;
      src2_signed <= wr_src2_signed;
      sel_lohi    <= wr_sel_lohi;
    end else if (success_hit) begin
      specbit <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_issue_queue.sv
// Multiplier reservation station and issue controller. Allocates dispatched
// ops to the lowest free entry, grants the lowest ready entry when the unit is
// idle or completing, and holds the issued op on the ex_* registers until the
// next grant. Optional stall counter: define MUL_STALL_CNT_EN.
module mul_issue_queue
  import mul_issue_queue_pkg::*;
#(
  parameter int ENTRY_NUM   = MUL_ENTRY_NUM,
  parameter int DATA_LEN    = MUL_DATA_LEN,
  parameter int RRF_SEL     = MUL_RRF_SEL,
  parameter int SPECTAG_LEN = MUL_SPECTAG_LEN
) (
  input  logic            clk,
  input  logic            reset,
  mul_issue_queue_if.master bus
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]   vld_vec, ready_vec, kill_vec, grant_vec;
  logic [ENTRY_NUM-1:0]   wr_sel, clr_sel;
  logic [IDX_W-1:0]       free_idx, grant_idx;
  logic                   can_issue;
  logic                   ex_kill, ex_success, grant_success;

  logic [DATA_LEN-1:0]    e_src1      [ENTRY_NUM];
  logic [DATA_LEN-1:0]    e_src2      [ENTRY_NUM];
  logic                   e_dstval    [ENTRY_NUM];
  logic [RRF_SEL-1:0]     e_rrftag    [ENTRY_NUM];
  logic [SPECTAG_LEN-1:0] e_spectag   [ENTRY_NUM];
  logic                   e_specbit   [ENTRY_NUM];
  logic                   e_s1_signed [ENTRY_NUM];
  logic                   e_s2_signed [ENTRY_NUM];
  logic                   e_sel_lohi  [ENTRY_NUM];

  assign bus.full  = &vld_vec;
  assign grant_vec = ready_vec & ~kill_vec;
  assign can_issue = (!bus.unit_busy || bus.ex_done) && |grant_vec;

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!vld_vec[i]) free_idx = IDX_W'(i);
    end
  end

  // Lowest-index ready entry that is not being killed wins the grant.
  always_comb begin
    grant_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (grant_vec[i]) grant_idx = IDX_W'(i);
    end
  end

  assign ex_kill       = bus.prmiss && bus.unit_busy && bus.ex_specbit &&
                         |(bus.ex_spectag & bus.spectagfix);
  assign ex_success    = bus.prsuccess && |(bus.ex_spectag & bus.spectagfix);
  assign grant_success = bus.prsuccess && |(e_spectag[grant_idx] & bus.spectagfix);

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
    assign wr_sel[i]  = bus.we && !bus.full && (free_idx == IDX_W'(i));
    assign clr_sel[i] = can_issue && (grant_idx == IDX_W'(i));

    mul_rs_entry #(
      .DATA_LEN    (DATA_LEN),
      .RRF_SEL     (RRF_SEL),
      .SPECTAG_LEN (SPECTAG_LEN)
    ) u_entry (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_sel[i]),
      .wr_src1        (bus.wr_src1),
      .wr_src2        (bus.wr_src2),
      .wr_src1_vld    (bus.wr_src1_vld),
      .wr_src2_vld    (bus.wr_src2_vld),
      .wr_dstval      (bus.wr_dstval),
      .wr_rrftag      (bus.wr_rrftag),
      .wr_spectag     (bus.wr_spectag),
      .wr_specbit     (bus.wr_specbit),
      .wr_src1_signed (bus.wr_src1_signed),
      .wr_src2_signed (bus.wr_src2_signed),
      .wr_sel_lohi    (bus.wr_sel_lohi),
      .fwd0_we        (bus.fwd0_we),
      .fwd0_tag       (bus.fwd0_tag),
      .fwd0_data      (bus.fwd0_data),
      .fwd1_we        (bus.fwd1_we),
      .fwd1_tag       (bus.fwd1_tag),
      .fwd1_data      (bus.fwd1_data),
      .prmiss         (bus.prmiss),
      .prsuccess      (bus.prsuccess),
      .spectagfix     (bus.spectagfix),
      .clear          (clr_sel[i]),
      .vld            (vld_vec[i]),
      .ready          (ready_vec[i]),
      .kill_hit       (kill_vec[i]),
      .src1           (e_src1[i]),
      .src2           (e_src2[i]),
      .dstval         (e_dstval[i]),
      .rrftag         (e_rrftag[i]),
      .spectag        (e_spectag[i]),
      .specbit        (e_specbit[i]),
      .src1_signed    (e_s1_signed[i]),
      .src2_signed    (e_s2_signed[i]),
      .sel_lohi       (e_sel_lohi[i])
    );
  end

  // Issue pulse, unit occupancy and the held operand/control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.issue          <= 1'b0;
      bus.unit_busy      <= 1'b0;
      bus.ex_src1        <= '0;
      bus.ex_src2        <= '0;
      bus.ex_dstval      <= 1'b0;
      bus.ex_rrftag      <= '0;
      bus.ex_spectag     <= '0;
      bus.ex_specbit     <= 1'b0;
      bus.ex_src1_signed <= 1'b0;
      bus.ex_src2_signed <= 1'b0;
      bus.ex_sel_lohi    <= 1'b0;
    end else begin
      bus.issue <= can_issue;
      if (can_issue) begin
        bus.unit_busy      <= 1'b1;
        bus.ex_src1        <= e_src1[grant_idx];
        bus.ex_src2        <= e_src2[grant_idx];
        bus.ex_dstval      <= e_dstval[grant_idx];
        bus.ex_rrftag      <= e_rrftag[grant_idx];
        bus.ex_spectag     <= e_spectag[grant_idx];
        bus.ex_specbit     <= e_specbit[grant_idx] && !grant_success;
        bus.ex_src1_signed <= e_s1_signed[grant_idx];
        bus.ex_src2_signed <= e_s2_signed[grant_idx];
        bus.ex_sel_lohi    <= e_sel_lohi[grant_idx];
      end else begin
        if (bus.ex_done || ex_kill) bus.unit_busy <= 1'b0;
        if (ex_success) bus.ex_specbit <= 1'b0;
      end
    end
  end

`ifdef MUL_STALL_CNT_EN
  // Cycles where a ready op waits behind a busy unit, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.stall_cnt <= '0;
    end else if (|ready_vec && bus.unit_busy && !bus.ex_done && (bus.stall_cnt != '1)) begin
      bus.stall_cnt <= bus.stall_cnt + 32'd1;
    end
  end
`endif

  // The dispatcher must never write into a full queue, and a branch resolves
  // either way but never both in one cycle.
  a_no_we_when_full: assert property (@(posedge clk) disable iff (!reset) !(bus.we && bus.full));
  a_branch_exclusive: assert property (@(posedge clk) disable iff (!reset) !(bus.prmiss && bus.prsuccess));

endmodule

// File: tb/tb_mul_issue_queue.sv
// Self-checking bench for mul_issue_queue: a directed vector table, directed
// fill / kill / reset sequences and randomized traffic, all compared against
// an array-based behavioural model of the issue queue.
module tb_mul_issue_queue;
  import mul_issue_queue_pkg::*;

  localparam int EN = MUL_ENTRY_NUM;
  localparam int DL = MUL_DATA_LEN;
  localparam int RS = MUL_RRF_SEL;
  localparam int SL = MUL_SPECTAG_LEN;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_issue_queue_if #(.DATA_LEN(DL), .RRF_SEL(RS), .SPECTAG_LEN(SL)) bus ();

  mul_issue_queue #(
    .ENTRY_NUM(EN), .DATA_LEN(DL), .RRF_SEL(RS), .SPECTAG_LEN(SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DL-1:0] s1;
    logic [DL-1:0] s2;
    bit            v1;
    bit            v2;
    bit            dstval;
    logic [RS-1:0] tag;
    logic [SL-1:0] stag;
    bit            sbit;
    bit            sg1;
    bit            sg2;
    bit            lohi;
  } op_t;

  op_t         m_e [EN];
  bit          m_v [EN];
  bit          m_issue;
  bit          m_busy;
  op_t         m_ex;
  logic [31:0] m_stall;

  task automatic model_reset();
    for (int i = 0; i < EN; i++) m_v[i] = 1'b0;
    m_issue = 1'b0;
    m_busy  = 1'b0;
    m_ex    = '{default: '0};
    m_stall = '0;
  endtask

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < EN; i++) if (!m_v[i]) f = 1'b0;
    return f;
  endfunction

  function automatic bit hit(input logic [SL-1:0] t);
    return (t & bus.spectagfix) != '0;
  endfunction

  function automatic op_t wake(input op_t o);
    op_t r = o;
    if (!r.v1) begin
      if (bus.fwd0_we && bus.fwd0_tag == r.s1[RS-1:0]) begin r.s1 = bus.fwd0_data; r.v1 = 1'b1; end
      else if (bus.fwd1_we && bus.fwd1_tag == r.s1[RS-1:0]) begin r.s1 = bus.fwd1_data; r.v1 = 1'b1; end
    end
    if (!r.v2) begin
      if (bus.fwd0_we && bus.fwd0_tag == r.s2[RS-1:0]) begin r.s2 = bus.fwd0_data; r.v2 = 1'b1; end
      else if (bus.fwd1_we && bus.fwd1_tag == r.s2[RS-1:0]) begin r.s2 = bus.fwd1_data; r.v2 = 1'b1; end
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int  g = -1;
    int  w = -1;
    bit  any_ready = 1'b0;
    bit  full_now = m_full();
    op_t n;
    for (int i = 0; i < EN; i++) begin
      bit rdy = m_v[i] && m_e[i].v1 && m_e[i].v2;
      if (rdy) any_ready = 1'b1;
      if (g < 0 && rdy && (!m_busy || bus.ex_done) && !(bus.prmiss && m_e[i].sbit && hit(m_e[i].stag))) g = i;
      if (w < 0 && !m_v[i]) w = i;
    end
    if (any_ready && m_busy && !bus.ex_done && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    m_issue = (g >= 0);
    if (g >= 0) begin
      m_ex = m_e[g];
      if (bus.prsuccess && hit(m_ex.stag)) m_ex.sbit = 1'b0;
      m_busy = 1'b1;
    end else begin
      if (bus.ex_done || (bus.prmiss && m_busy && m_ex.sbit && hit(m_ex.stag))) m_busy = 1'b0;
      if (bus.prsuccess && hit(m_ex.stag)) m_ex.sbit = 1'b0;
    end
    for (int i = 0; i < EN; i++) begin
      if (m_v[i]) begin
        if (i == g || (bus.prmiss && m_e[i].sbit && hit(m_e[i].stag))) m_v[i] = 1'b0;
        else begin
          if (bus.prsuccess && hit(m_e[i].stag)) m_e[i].sbit = 1'b0;
          m_e[i] = wake(m_e[i]);
        end
      end
    end
    if (bus.we && !full_now) begin
      n.s1 = bus.wr_src1; n.v1 = bus.wr_src1_vld;
      n.s2 = bus.wr_src2; n.v2 = bus.wr_src2_vld;
      n.dstval = bus.wr_dstval; n.tag = bus.wr_rrftag;
      n.stag = bus.wr_spectag; n.sbit = bus.wr_specbit;
      n.sg1 = bus.wr_src1_signed; n.sg2 = bus.wr_src2_signed; n.lohi = bus.wr_sel_lohi;
      if (bus.prsuccess && hit(n.stag)) n.sbit = 1'b0;
      n = wake(n);
      if (!(bus.prmiss && bus.wr_specbit && hit(n.stag))) begin
        m_e[w] = n;
        m_v[w] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("issue", 64'(bus.issue), 64'(m_issue));
    check("unit_busy", 64'(bus.unit_busy), 64'(m_busy));
    check("full", 64'(bus.full), 64'(m_full()));
    check("ex_src1", 64'(bus.ex_src1), 64'(m_ex.s1));
    check("ex_src2", 64'(bus.ex_src2), 64'(m_ex.s2));
    check("ex_ctrl",
          64'({bus.ex_dstval, bus.ex_rrftag, bus.ex_spectag, bus.ex_specbit,
               bus.ex_src1_signed, bus.ex_src2_signed, bus.ex_sel_lohi}),
          64'({m_ex.dstval, m_ex.tag, m_ex.stag, m_ex.sbit, m_ex.sg1, m_ex.sg2, m_ex.lohi}));
`ifdef MUL_STALL_CNT_EN
    check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.we = 1'b0; bus.wr_src1 = '0; bus.wr_src2 = '0;
    bus.wr_src1_vld = 1'b0; bus.wr_src2_vld = 1'b0; bus.wr_dstval = 1'b0;
    bus.wr_rrftag = '0; bus.wr_spectag = '0; bus.wr_specbit = 1'b0;
    bus.wr_src1_signed = 1'b0; bus.wr_src2_signed = 1'b0; bus.wr_sel_lohi = 1'b0;
    bus.fwd0_we = 1'b0; bus.fwd0_tag = '0; bus.fwd0_data = '0;
    bus.fwd1_we = 1'b0; bus.fwd1_tag = '0; bus.fwd1_data = '0;
    bus.prmiss = 1'b0; bus.prsuccess = 1'b0; bus.spectagfix = '0;
    bus.ex_done = 1'b0;
  endtask

  task automatic dispatch(input logic [DL-1:0] s1, input bit v1, input logic [DL-1:0] s2,
                          input bit v2, input logic [SL-1:0] stag, input bit sbit);
    bus.we = 1'b1; bus.wr_src1 = s1; bus.wr_src1_vld = v1;
    bus.wr_src2 = s2; bus.wr_src2_vld = v2;
    bus.wr_spectag = stag; bus.wr_specbit = sbit; bus.wr_dstval = 1'b1;
  endtask

  // One clock: advance the model, let the edge happen, compare 1 ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [SL-1:0] onehot();
    return SL'(1) << $urandom_range(SL - 1, 0);
  endfunction

  task automatic rand_inputs();
    int r;
    idle();
    bus.we = !m_full() && ($urandom_range(99) < 55);
    bus.wr_src1 = $urandom; bus.wr_src1_vld = 1'($urandom_range(1));
    bus.wr_src2 = $urandom; bus.wr_src2_vld = 1'($urandom_range(1));
    if (!bus.wr_src1_vld) bus.wr_src1[RS-1:0] = RS'($urandom_range(7));
    if (!bus.wr_src2_vld) bus.wr_src2[RS-1:0] = RS'($urandom_range(7));
    bus.wr_dstval = 1'($urandom_range(1));
    bus.wr_rrftag = RS'($urandom);
    bus.wr_spectag = onehot();
    bus.wr_specbit = 1'($urandom_range(1));
    bus.wr_src1_signed = 1'($urandom_range(1));
    bus.wr_src2_signed = 1'($urandom_range(1));
    bus.wr_sel_lohi = 1'($urandom_range(1));
    bus.fwd0_we = ($urandom_range(99) < 35); bus.fwd0_tag = RS'($urandom_range(7)); bus.fwd0_data = $urandom;
    bus.fwd1_we = ($urandom_range(99) < 35); bus.fwd1_tag = RS'($urandom_range(7)); bus.fwd1_data = $urandom;
    r = int'($urandom_range(99));
    bus.prmiss = (r < 5);
    bus.prsuccess = (r >= 5 && r < 12);
    bus.spectagfix = onehot();
    bus.ex_done = m_busy && ($urandom_range(99) < 40);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            we;
    logic [DL-1:0] s1;
    bit            v1;
    logic [DL-1:0] s2;
    bit            v2;
    bit            f1_we;
    logic [RS-1:0] f1_tag;
    logic [DL-1:0] f1_data;
    bit            ex_done;
    bit            e_issue;
    bit            e_busy;
    bit            e_full;
    logic [DL-1:0] e_src1;
    logic [DL-1:0] e_src2;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we  s1  v1  s2 v2 f1we tag data exd  iss busy full src1 src2
    tbl[0]  = '{1, 3,  1, 5,  1, 0, 0, 0, 0,   0, 0, 0, 0,  0};
    tbl[1]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 3,  5};
    tbl[2]  = '{1, 11, 1, 9,  0, 0, 0, 0, 1,   0, 0, 0, 3,  5};
    tbl[3]  = '{0, 0,  0, 0,  0, 1, 9, 7, 0,   0, 0, 0, 3,  5};
    tbl[4]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 11, 7};
    tbl[5]  = '{1, 20, 1, 21, 1, 0, 0, 0, 0,   0, 1, 0, 11, 7};
    tbl[6]  = '{1, 30, 1, 31, 1, 0, 0, 0, 0,   0, 1, 0, 11, 7};
    tbl[7]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 11, 7};
    tbl[8]  = '{0, 0,  0, 0,  0, 0, 0, 0, 1,   1, 1, 0, 20, 21};
    tbl[9]  = '{0, 0,  0, 0,  0, 0, 0, 0, 1,   1, 1, 0, 30, 31};
    tbl[10] = '{0, 0,  0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 30, 31};
    tbl[11] = '{0, 0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 30, 31};

    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #2 reset = 1'b1;

    // Directed vectors: basic issue, fwd1 wakeup, back-to-back issue on ex_done.
    for (int k = 0; k < 12; k++) begin
      idle();
      bus.we = tbl[k].we;
      bus.wr_src1 = tbl[k].s1; bus.wr_src1_vld = tbl[k].v1;
      bus.wr_src2 = tbl[k].s2; bus.wr_src2_vld = tbl[k].v2;
      bus.wr_rrftag = RS'(k); bus.wr_dstval = tbl[k].we;
      bus.fwd1_we = tbl[k].f1_we; bus.fwd1_tag = tbl[k].f1_tag; bus.fwd1_data = tbl[k].f1_data;
      bus.ex_done = tbl[k].ex_done;
      tick();
      check($sformatf("tbl%0d_issue", k), 64'(bus.issue), 64'(tbl[k].e_issue));
      check($sformatf("tbl%0d_busy", k), 64'(bus.unit_busy), 64'(tbl[k].e_busy));
      check($sformatf("tbl%0d_full", k), 64'(bus.full), 64'(tbl[k].e_full));
      check($sformatf("tbl%0d_src1", k), 64'(bus.ex_src1), 64'(tbl[k].e_src1));
      check($sformatf("tbl%0d_src2", k), 64'(bus.ex_src2), 64'(tbl[k].e_src2));
    end

    // Fill all entries with ops waiting on tag 40, then release them.
    for (int i = 0; i < EN; i++) begin
      idle();
      dispatch(DL'(40), 1'b0, DL'(i + 1), 1'b1, '0, 1'b0);
      tick();
    end
    check("fill_full", 64'(bus.full), 64'd1);
    idle();
    bus.fwd0_we = 1'b1; bus.fwd0_tag = RS'(40); bus.fwd0_data = DL'(100);
    tick();
    check("fill_full_hold", 64'(bus.full), 64'd1);
    check("fill_no_issue", 64'(bus.issue), 64'd0);
    idle();
    tick();
    check("fill_issue", 64'(bus.issue), 64'd1);
    check("fill_full_released", 64'(bus.full), 64'd0);
    check("fill_src1", 64'(bus.ex_src1), 64'd100);
    check("fill_src2", 64'(bus.ex_src2), 64'd1);
    for (int i = 0; i < EN + 2; i++) begin
      idle();
      bus.ex_done = m_busy;
      tick();
    end
    check("fill_drained", 64'(bus.unit_busy), 64'd0);

    // Mispredict kills the in-flight op and a matching queued op.
    idle(); dispatch(DL'(50), 1'b1, DL'(51), 1'b1, 5'b00010, 1'b1); tick();
    idle(); tick();
    check("kill_setup_issue", 64'(bus.issue), 64'd1);
    check("kill_setup_specbit", 64'(bus.ex_specbit), 64'd1);
    idle(); dispatch(DL'(60), 1'b1, DL'(61), 1'b1, 5'b00010, 1'b1); tick();
    idle(); dispatch(DL'(70), 1'b1, DL'(71), 1'b1, 5'b00100, 1'b1); tick();
    idle(); bus.prmiss = 1'b1; bus.spectagfix = 5'b00010; tick();
    check("kill_busy_cleared", 64'(bus.unit_busy), 64'd0);
    check("kill_no_issue", 64'(bus.issue), 64'd0);
    check("kill_ex_hold", 64'(bus.ex_src1), 64'd50);
    idle(); tick();
    check("kill_survivor_issue", 64'(bus.issue), 64'd1);
    check("kill_survivor_src1", 64'(bus.ex_src1), 64'd70);
    idle(); bus.ex_done = 1'b1; tick();
    idle(); tick();
    check("kill_queue_empty", 64'(bus.issue), 64'd0);

    // Reset mid-execution with an op still queued.
    idle(); dispatch(DL'(77), 1'b1, DL'(78), 1'b1, '0, 1'b0); tick();
    idle(); dispatch(DL'(88), 1'b1, DL'(89), 1'b1, '0, 1'b0); tick();
    check("rst_setup_busy", 64'(bus.unit_busy), 64'd1);
    idle();
    #2 reset = 1'b0;
    #1;
    check("rst_issue", 64'(bus.issue), 64'd0);
    check("rst_busy", 64'(bus.unit_busy), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_src1", 64'(bus.ex_src1), 64'd0);
    check("rst_src2", 64'(bus.ex_src2), 64'd0);
    check("rst_ctrl", 64'({bus.ex_dstval, bus.ex_rrftag, bus.ex_spectag, bus.ex_specbit}), 64'd0);
    #2 reset = 1'b1;
    model_reset();
    idle(); tick();
    check("rst_queue_dropped", 64'(bus.issue), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_issue_queue.md
Name: mul_issue_queue

Overview:
- Reservation station and issue controller on the issuing side of the multiplier execution unit's issue handshake.
- Holds dispatched multiply ops and captures missing operands from two result-forwarding buses.
- Selects a ready op and drives the unit's issue pulse and operands, holding the operands stable for the whole variable-latency execution.
- Tracks unit occupancy from the unit's completion strobe and applies branch-miss kill and branch-success tag clearing.

Parameters:
- ENTRY_NUM, 4, number of station entries (2..8).
- DATA_LEN, 32, operand width.
- RRF_SEL, 6, rename-register tag width.
- SPECTAG_LEN, 5, one-hot speculative-tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  dispatch write strobe.
- wr_src1, wr_src2  in  DATA_LEN  operand value, or source tag in bits [RRF_SEL-1:0] when not valid.
- wr_src1_vld, wr_src2_vld  in  1  operand is a value.
- wr_dstval  in  1  op writes a register.
- wr_rrftag  in  RRF_SEL  destination tag.
- wr_spectag  in  SPECTAG_LEN  speculative tag.
- wr_specbit  in  1  op is speculative.
- wr_src1_signed, wr_src2_signed, wr_sel_lohi  in  1  multiply controls.
- full  out  1  no free entry.
- fwd0_we, fwd1_we  in  1  forwarding-bus valid.
- fwd0_tag, fwd1_tag  in  RRF_SEL  forwarding-bus tag.
- fwd0_data, fwd1_data  in  DATA_LEN  forwarding-bus data.
- prmiss, prsuccess  in  1  branch resolved mispredicted / correct.
- spectagfix  in  SPECTAG_LEN  tag of the resolved branch.
- ex_done  in  1  unit completion strobe (unit's ROB write enable).
- issue  out  1  one-cycle issue pulse to the unit.
- ex_src1, ex_src2  out  DATA_LEN  operands, held until completion.
- ex_dstval, ex_rrftag, ex_spectag, ex_specbit, ex_src1_signed, ex_src2_signed, ex_sel_lohi  out  held controls.
- unit_busy  out  1  an op is in flight.

Behaviour:
- Reset (asynchronous, reset=0) clears all entry valids, issue, unit_busy, and every ex_* register to 0.
- Allocation: when we=1 and full=0, write to the lowest-index free entry at the clock edge.
- we=1 while full=1 is ignored; this is a protocol error and is asserted against.
- full = all entries valid, combinational, with no lookahead for entries freed this cycle.
- Wakeup: for each invalid source, if fwdN_we=1 and fwdN_tag equals the stored tag, latch fwdN_data and set the valid bit.
  - Wakeup also applies to a source being written in the same cycle.
  - If both buses match, fwd0 wins.
- Ready: entry valid and both sources valid, evaluated on registered state only.
  - An op dispatched at edge D can issue at the earliest at edge D+1.
- Issue grant: can_issue = (!unit_busy || ex_done) && any ready entry, where the ready entry is not being killed this cycle.
  - The winner is the lowest-index ready entry.
  - At the edge: copy the winner to the ex_* registers, free the entry, set issue=1 and unit_busy=1.
  - Otherwise issue=0. issue is high for exactly one cycle.
- ex_done=1 with no new grant clears unit_busy. The ex_* registers keep their last values.
- Kill: when prmiss=1, every entry with specbit=1 and (spectag & spectagfix)!=0 is invalidated.
  - If the in-flight op matches, clear unit_busy and issue. The unit discards the op on its own.
  - A kill overrides a same-cycle grant of the killed op. The next ready entry may be granted instead.
- Branch success: when prsuccess=1, clear specbit on matching entries and on ex_specbit.
- prmiss and prsuccess are never both high in the same cycle.
- A kill and a dispatch in the same cycle: the incoming op is written unless it matches the kill condition.
- Reset asserted mid-operation drops all state immediately.

Optional Feature:
- MUL_STALL_CNT_EN defined: adds output stall_cnt [31:0].
  - Increments on each cycle with at least one ready entry and unit_busy=1 and ex_done=0.
  - Saturates at 32'hFFFFFFFF; reset value 0.
- MUL_STALL_CNT_EN undefined: no port, no counter logic.

Decomposition:
- DATA_LEN, RRF_SEL, SPECTAG_LEN and ENTRY_NUM defaults come from the shared constants header.
- One sub-module, mul_rs_entry: one entry's storage, wakeup compare for both sources, kill/success update, and ready output.
- Selection and the ex_* registers stay in the top module.

Test Plan:
- Dispatch src1=3, src2=5, both valid, unit idle → issue pulses one cycle after the write edge; ex_src1=3, ex_src2=5; unit_busy=1 until ex_done.
- Dispatch src2 invalid with tag 6'd9, then fwd1 broadcasts tag 9 with data 7 → entry issues the following cycle with ex_src2=7.
- Two ready ops while busy; ex_done pulses → the second issues at the ex_done edge with no idle cycle; ex_* registers stay stable until then.
- Fill 4 entries → full=1; extra we ignored; after one issue, full=0 the next cycle.
- In-flight op spectag=5'b00010, specbit=1; prmiss with spectagfix=5'b00010 → unit_busy=0, matching queued entries dropped, non-matching entry issues next.
- Assert reset mid-execution → all outputs 0 immediately.
